// File: rtl/stopwatch_scan_controller.sv
// stopwatch_scan_controller: timebase, BCD SS.hh counter and 4-digit scan mux.
// Define STOPWATCH_LAP_EN to add the lap snapshot display register.
module stopwatch_scan_controller #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 100,
   parameter int SCAN_HZ = 1000
) (
   input  logic       clk,
   input  logic       sys_rst_n,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] num_out,
   output logic [1:0] ctrl_led,
   output logic       running,
   output logic       wrapped
);
   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int TW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2;

   if (TICK_DIV * TICK_HZ != CLK_HZ || TICK_DIV < 2) begin : g_bad_tick_div
      $error("CLK_HZ/TICK_HZ must divide exactly and be at least 2");
   end
   if (SCAN_DIV * SCAN_HZ != CLK_HZ || SCAN_DIV < 2) begin : g_bad_scan_div
      $error("CLK_HZ/SCAN_HZ must divide exactly and be at least 2");
   end

   function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] lim);
      return (d >= lim) ? 4'd0 : d + 4'd1;
   endfunction

   logic [1:0]      state_q, state_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
   logic [1:0]      sel_q, sel_d;
   logic [3:0][3:0] dig_q, dig_d, shown;
   logic [3:0]      num_q, num_d;
   logic            running_q, running_d, wrapped_q, wrapped_d, tick, scan_adv;
`ifdef STOPWATCH_LAP_EN
   logic            hold_q, hold_d;
   logic [3:0][3:0] snap_q, snap_d;
`else
   logic            unused_lap;
   assign unused_lap = lap;
`endif

   always_comb begin
      tick = state_q == RUN && tick_cnt_q == TW'(TICK_DIV - 1);
      state_d = state_q;
      if (clear) state_d = IDLE;
      else if (start_stop) state_d = (state_q == RUN) ? PAUSE : RUN;
      tick_cnt_d = tick_cnt_q;
      if (clear || (state_q == IDLE && start_stop)) tick_cnt_d = '0;
      else if (state_q == RUN) tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      dig_d = dig_q;
      wrapped_d = wrapped_q;
      // ripple carry: each digit advances only when every lower digit is at its limit
      if (clear) begin
         dig_d = '0;
         wrapped_d = 1'b0;
      end else if (tick) begin
         dig_d[0] = bcd_inc(dig_q[0], 4'd9);
         if (dig_q[0] >= 4'd9) begin
            dig_d[1] = bcd_inc(dig_q[1], 4'd9);
            if (dig_q[1] >= 4'd9) begin
               dig_d[2] = bcd_inc(dig_q[2], 4'd9);
               if (dig_q[2] >= 4'd9) begin
                  dig_d[3] = bcd_inc(dig_q[3], 4'd5);
                  if (dig_q[3] >= 4'd5) wrapped_d = 1'b1;
               end
            end
         end
      end
      scan_adv = scan_cnt_q == SW'(SCAN_DIV - 1);
      scan_cnt_d = scan_adv ? '0 : scan_cnt_q + 1'b1;
      sel_d = scan_adv ? sel_q + 2'd1 : sel_q;
`ifdef STOPWATCH_LAP_EN
      hold_d = hold_q;
      snap_d = snap_q;
      if (clear) hold_d = 1'b0;
      else if (lap && state_q == RUN) begin
         hold_d = ~hold_q;
         snap_d = hold_q ? snap_q : dig_q;
      end
      shown = hold_q ? snap_q : dig_q;
`else
      shown = dig_q;
`endif
      // num_out uses the next select so digit and select change together
      num_d = shown[sel_d];
      running_d = state_d == RUN;
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         scan_cnt_q <= '0;
         sel_q      <= '0;
         dig_q      <= '0;
         num_q      <= '0;
         running_q  <= 1'b0;
         wrapped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         scan_cnt_q <= scan_cnt_d;
         sel_q      <= sel_d;
         dig_q      <= dig_d;
         num_q      <= num_d;
         running_q  <= running_d;
         wrapped_q  <= wrapped_d;
      end
   end

`ifdef STOPWATCH_LAP_EN
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hold_q <= 1'b0;
         snap_q <= '0;
      end else begin
         hold_q <= hold_d;
         snap_q <= snap_d;
      end
   end
`endif

   assign num_out  = num_q;
   assign ctrl_led = sel_q;
   assign running  = running_q;
   assign wrapped  = wrapped_q;
endmodule

// File: tb/tb_stopwatch_scan_controller.sv
// tb_stopwatch_scan_controller: random and directed checks against a time-based model.
module tb_stopwatch_scan_controller;
   logic       clk = 1'b0, sys_rst_n = 1'b1, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
   logic [3:0] num_out;
   logic [1:0] ctrl_led;
   logic       running, wrapped;
   int         vectors = 0, miscompares = 0;

   stopwatch_scan_controller #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(250)) dut (
      .clk(clk), .sys_rst_n(sys_rst_n), .start_stop(start_stop), .clear(clear), .lap(lap),
      .num_out(num_out), .ctrl_led(ctrl_led), .running(running), .wrapped(wrapped)
   );

   always #5 clk = ~clk;

   // model: elapsed time is RUN clock count / 10 hundredths, modulo 60.00 s
   int         m_mode, m_cyc, m_edges, m_snap;
   bit         m_hold, m_wrap;
   logic [3:0] m_num;

   function automatic logic [3:0] digit_of(input int v, input int i);
      case (i)
         0: return 4'(v % 10);
         1: return 4'((v / 10) % 10);
         2: return 4'((v / 100) % 10);
         default: return 4'(v / 1000);
      endcase
   endfunction

   function int disp_val();
      return m_hold ? m_snap : (m_cyc / 10) % 6000;
   endfunction

   function logic [1:0] exp_sel();
      return 2'((m_edges / 4) % 4);
   endfunction

   function logic [7:0] exp_obs();
      return {exp_sel(), m_num, m_mode == 1, m_wrap};
   endfunction

   function void model_reset();
      m_mode = 0; m_cyc = 0; m_edges = 0; m_snap = 0; m_hold = 0; m_wrap = 0; m_num = 0;
   endfunction

   function void model_edge(input bit ss, input bit cl, input bit lp);
      int old_disp, old_cyc;
      old_disp = disp_val();
      old_cyc = m_cyc;
      if (cl) begin
         m_mode = 0; m_cyc = 0; m_wrap = 0; m_hold = 0;
      end else begin
         if (m_mode == 1) begin
            m_cyc++;
            if (m_cyc % 60000 == 0) m_wrap = 1;
         end
`ifdef STOPWATCH_LAP_EN
         if (lp && m_mode == 1) begin
            if (m_hold) m_hold = 0;
            else begin
               m_hold = 1;
               m_snap = (old_cyc / 10) % 6000;
            end
         end
`else
         if (lp && old_cyc < 0) m_hold = 0;
`endif
         if (ss) m_mode = (m_mode == 1) ? 2 : 1;
      end
      m_edges++;
      m_num = digit_of(old_disp, int'(exp_sel()));
   endfunction

   task automatic cycle(input bit ss, input bit cl, input bit lp);
      start_stop = ss; clear = cl; lap = lp;
      @(posedge clk);
      model_edge(ss, cl, lp);
      @(negedge clk);
      start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
   endtask

   task automatic test_reset();
      #2 sys_rst_n = 1'b0;
      #1;
      vectors++;
      if ({ctrl_led, num_out, running, wrapped} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_state: got %h want 00", {ctrl_led, num_out, running, wrapped});
      end
      repeat (2) @(negedge clk);
      sys_rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 24; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if ({ctrl_led, num_out, running, wrapped} !== {2'((i + 1) / 4 % 4), 6'h00}) begin
            miscompares++;
            $display("FAIL idle_scan %0d: got %h want %h", i, {ctrl_led, num_out, running, wrapped}, {2'((i + 1) / 4 % 4), 6'h00});
         end
      end
   endtask

   task automatic test_run_basic();
      cycle(0, 1, 0);
      cycle(1, 0, 0);
      vectors++;
      if (running !== 1'b1) begin
         miscompares++;
         $display("FAIL start_running: got %b want 1", running);
      end
      for (int i = 0; i < 1000; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if ({ctrl_led, num_out, running, wrapped} !== exp_obs()) begin
            miscompares++;
            $display("FAIL run_basic cyc %0d: got %h want %h", i, {ctrl_led, num_out, running, wrapped}, exp_obs());
         end
      end
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if (num_out !== digit_of(100, int'(exp_sel()))) begin
            miscompares++;
            $display("FAIL show_01_00 %0d: got %0d want %0d", i, num_out, digit_of(100, int'(exp_sel())));
         end
      end
   endtask

   task automatic test_wrap();
      cycle(0, 1, 0);
      cycle(1, 0, 0);
      for (int i = 0; i < 59991; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if ({ctrl_led, num_out, running, wrapped} !== exp_obs()) begin
            miscompares++;
            $display("FAIL wrap_run cyc %0d: got %h want %h", i, {ctrl_led, num_out, running, wrapped}, exp_obs());
         end
      end
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if ({num_out, wrapped} !== {digit_of(5999, int'(exp_sel())), 1'b0}) begin
            miscompares++;
            $display("FAIL show_59_99 %0d: got %h want %h", i, {num_out, wrapped}, {digit_of(5999, int'(exp_sel())), 1'b0});
         end
      end
      cycle(0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if ({num_out, running, wrapped} !== 6'b0000_11) begin
            miscompares++;
            $display("FAIL rollover %0d: got %b want 000011", i, {num_out, running, wrapped});
         end
      end
      cycle(0, 1, 0);
      vectors++;
      if ({running, wrapped} !== 2'b00) begin
         miscompares++;
         $display("FAIL clear_wrapped: got %b want 00", {running, wrapped});
      end
   endtask

   task automatic test_pause();
      cycle(0, 1, 0);
      cycle(1, 0, 0);
      repeat (370) cycle(0, 0, 0);
      cycle(1, 0, 0);
      for (int i = 0; i < 500; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if ({ctrl_led, num_out, running, wrapped} !== {exp_sel(), digit_of(37, int'(exp_sel())), 2'b00}) begin
            miscompares++;
            $display("FAIL pause_hold %0d: got %h want %h", i, {ctrl_led, num_out, running, wrapped}, {exp_sel(), digit_of(37, int'(exp_sel())), 2'b00});
         end
      end
      cycle(1, 0, 0);
      for (int i = 0; i < 9; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if ({num_out, running} !== {digit_of(37, int'(exp_sel())), 1'b1}) begin
            miscompares++;
            $display("FAIL resume_partial %0d: got %h want %h", i, {num_out, running}, {digit_of(37, int'(exp_sel())), 1'b1});
         end
      end
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if (num_out !== digit_of(38, int'(exp_sel()))) begin
            miscompares++;
            $display("FAIL resume_tick %0d: got %0d want %0d", i, num_out, digit_of(38, int'(exp_sel())));
         end
      end
   endtask

   task automatic test_clear_wins();
      cycle(0, 1, 0);
      cycle(1, 0, 0);
      repeat (55) cycle(0, 0, 0);
      cycle(1, 1, 0);
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if ({num_out, running, wrapped} !== 6'h00 || {ctrl_led, num_out, running, wrapped} !== exp_obs()) begin
            miscompares++;
            $display("FAIL clear_wins %0d: got %h want %h", i, {ctrl_led, num_out, running, wrapped}, exp_obs());
         end
      end
   endtask

   task automatic test_lap();
      cycle(0, 1, 0);
      cycle(1, 0, 0);
      repeat (120) cycle(0, 0, 0);
      cycle(0, 0, 1);
      for (int i = 0; i < 491; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if ({ctrl_led, num_out, running, wrapped} !== exp_obs()) begin
            miscompares++;
            $display("FAIL lap_run cyc %0d: got %h want %h", i, {ctrl_led, num_out, running, wrapped}, exp_obs());
         end
      end
`ifdef STOPWATCH_LAP_EN
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if (num_out !== digit_of(12, int'(exp_sel()))) begin
            miscompares++;
            $display("FAIL lap_frozen %0d: got %0d want %0d", i, num_out, digit_of(12, int'(exp_sel())));
         end
      end
`else
      repeat (8) cycle(0, 0, 0);
`endif
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      for (int i = 0; i < 7; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if (num_out !== digit_of(62, int'(exp_sel()))) begin
            miscompares++;
            $display("FAIL lap_release %0d: got %0d want %0d", i, num_out, digit_of(62, int'(exp_sel())));
         end
      end
   endtask

   task automatic test_random();
      cycle(0, 1, 0);
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0);
         vectors++;
         if ({ctrl_led, num_out, running, wrapped} !== exp_obs()) begin
            miscompares++;
            $display("FAIL random cyc %0d: got %h want %h", i, {ctrl_led, num_out, running, wrapped}, exp_obs());
         end
      end
   endtask

   task automatic test_reset_mid();
      cycle(0, 1, 0);
      cycle(1, 0, 0);
      repeat (29) cycle(0, 0, 0);
      #2 sys_rst_n = 1'b0;
      #1;
      vectors++;
      if ({ctrl_led, num_out, running, wrapped} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_mid: got %h want 00", {ctrl_led, num_out, running, wrapped});
      end
      @(negedge clk);
      sys_rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 12; i++) begin
         cycle(0, 0, 0);
         vectors++;
         if ({ctrl_led, num_out, running, wrapped} !== exp_obs()) begin
            miscompares++;
            $display("FAIL after_reset %0d: got %h want %h", i, {ctrl_led, num_out, running, wrapped}, exp_obs());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_run_basic();
      test_wrap();
      test_pause();
      test_clear_wins();
      test_lap();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
